score_display: RTL

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/score_display.sv
// Score keeper for a two-player game plus a 3-stage pixel pipeline that drives
// an external registered digit glyph ROM and gates its output into score_pixel.
module score_display #(
  parameter logic [9:0] LEFT_X      = 10'd256,
  parameter logic [9:0] RIGHT_X     = 10'd360,
  parameter logic [9:0] TOP_Y       = 10'd32,
  parameter int         SCALE_SHIFT = 3,
  parameter logic [3:0] WIN_SCORE   = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       point_left,
  input  logic       point_right,
  input  logic       new_game,
  output logic [1:0] glyph_xpos,
  output logic [2:0] glyph_ypos,
  output logic [3:0] glyph_value,
  input  logic       glyph_pixel,
  output logic       score_pixel,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over
);

  // A glyph is 3 cells wide and 5 cells tall, each cell 2^SCALE_SHIFT pixels.
  localparam logic [9:0] DIGIT_W = 10'(3 << SCALE_SHIFT);
  localparam logic [9:0] DIGIT_H = 10'(5 << SCALE_SHIFT);

  logic [9:0] dxLeft;
  logic [9:0] dxRight;
  logic [9:0] dy;
  logic       dyInside;
  logic       inLeft;
  logic       inRight;

  logic [1:0] glyphXpos_d, glyphXpos_q;
  logic [2:0] glyphYpos_d, glyphYpos_q;
  logic [3:0] glyphValue_d, glyphValue_q;
  logic       inDigit1_d, inDigit1_q;
  logic       inDigit2_q;
  logic       scorePixel_d, scorePixel_q;

  logic [3:0] scoreLeft_d, scoreLeft_q;
  logic [3:0] scoreRight_d, scoreRight_q;
  logic       gameOver_d, gameOver_q;
  logic       pointLeftPrev_q;
  logic       pointRightPrev_q;
  logic       pointLeftEdge;
  logic       pointRightEdge;
  logic       reachedWin;

  // Unsigned wrap makes positions left of / above a digit look huge, so a
  // single less-than test covers both edges of the box.
  assign dxLeft   = hpos - LEFT_X;
  assign dxRight  = hpos - RIGHT_X;
  assign dy       = vpos - TOP_Y;
  assign dyInside = (dy < DIGIT_H);
  assign inLeft   = (dxLeft < DIGIT_W) && dyInside;
  assign inRight  = (dxRight < DIGIT_W) && dyInside;

  always_comb begin
    glyphXpos_d  = '0;
    glyphYpos_d  = '0;
    glyphValue_d = '0;
    inDigit1_d   = 1'b0;
    if (inLeft) begin
      glyphXpos_d  = 2'(dxLeft >> SCALE_SHIFT);
      glyphYpos_d  = 3'(dy >> SCALE_SHIFT);
      glyphValue_d = scoreLeft_q;
      inDigit1_d   = 1'b1;
    end else if (inRight) begin
      glyphXpos_d  = 2'(dxRight >> SCALE_SHIFT);
      glyphYpos_d  = 3'(dy >> SCALE_SHIFT);
      glyphValue_d = scoreRight_q;
      inDigit1_d   = 1'b1;
    end
  end

  assign scorePixel_d = glyph_pixel & inDigit2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      glyphXpos_q  <= '0;
      glyphYpos_q  <= '0;
      glyphValue_q <= '0;
      inDigit1_q   <= 1'b0;
      inDigit2_q   <= 1'b0;
      scorePixel_q <= 1'b0;
    end else begin
      glyphXpos_q  <= glyphXpos_d;
      glyphYpos_q  <= glyphYpos_d;
      glyphValue_q <= glyphValue_d;
      inDigit1_q   <= inDigit1_d;
      inDigit2_q   <= inDigit1_q;
      scorePixel_q <= scorePixel_d;
    end
  end

  // History resets high so a point input already high at reset release is
  // treated as old news rather than a fresh score.
  assign pointLeftEdge  = point_left & ~pointLeftPrev_q;
  assign pointRightEdge = point_right & ~pointRightPrev_q;
  assign reachedWin     = (scoreLeft_q == WIN_SCORE) || (scoreRight_q == WIN_SCORE);

  always_comb begin
    scoreLeft_d  = scoreLeft_q;
    scoreRight_d = scoreRight_q;
    gameOver_d   = gameOver_q | reachedWin;
    if (new_game) begin
      scoreLeft_d  = '0;
      scoreRight_d = '0;
      gameOver_d   = 1'b0;
    end else if (!gameOver_q) begin
      if (pointLeftEdge && (scoreLeft_q < WIN_SCORE)) begin
        scoreLeft_d = scoreLeft_q + 4'd1;
      end
      if (pointRightEdge && (scoreRight_q < WIN_SCORE)) begin
        scoreRight_d = scoreRight_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scoreLeft_q      <= '0;
      scoreRight_q     <= '0;
      gameOver_q       <= 1'b0;
      pointLeftPrev_q  <= 1'b1;
      pointRightPrev_q <= 1'b1;
    end else begin
      scoreLeft_q      <= scoreLeft_d;
      scoreRight_q     <= scoreRight_d;
      gameOver_q       <= gameOver_d;
      pointLeftPrev_q  <= point_left;
      pointRightPrev_q <= point_right;
    end
  end

  assign glyph_xpos  = glyphXpos_q;
  assign glyph_ypos  = glyphYpos_q;
  assign glyph_value = glyphValue_q;
  assign score_pixel = scorePixel_q;
  assign score_left  = scoreLeft_q;
  assign score_right = scoreRight_q;
  assign game_over   = gameOver_q;

endmodule
